coil_fire_sequencer: RTL and testbench
======================================

Name: coil_fire_sequencer

Overview:
Memory-mapped sequencer for one coil shot. It charges the capacitor bank through the boost converter, then stops switching and lets the boost stage settle. It then gates the coil switch for a programmed pulse width and holds off re-arming for a cooldown period. It sits between the CPU bus and the boost converter controller: it drives the boost enable and reads back the boost status and Vout ADC.

Parameters:
BASE_ADDR, 32'h00000100, bus base address; decoded window is 20 bytes.
CHARGE_TIMEOUT, 24'd10000000, max CHARGE cycles before the error abort.
SETTLE_TIME, 16'd200, cycles of boost-off before the gate is raised.
COOLDOWN_TIME, 24'd1000000, cycles after the pulse before returning to IDLE.
ENABLE_LAG, 4'd4, CHARGE cycles during which boost_running_i is ignored.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
mem_valid_i  in  1  bus request
mem_ready_o  out  1  one-cycle acknowledge
mem_addr_i  in  32  byte address
mem_wdata_i  in  32  write data
mem_wstrb_i  in  4  write strobes; any bit set means write
mem_rdata_o  out  32  read data, valid only with mem_ready_o
boost_running_i  in  1  boost controller is switching
boost_init_finished_i  in  1  current-null calibration complete
vout_adc_i  in  12  output-voltage ADC code
boost_enable_o  out  1  to the boost controller's enable
coil_gate_o  out  1  coil switch gate
busy_o  out  1  high in any state except IDLE
irq_o  out  1  one-cycle pulse on sequence completion or error

Behaviour:
- Reset (asynchronous, reset=0): all outputs 0; state IDLE; PULSE_WIDTH=0; VOUT_MIN=0; all flags 0.
- Bus handshake:
  - mem_ready_o pulses for exactly one cycle, the cycle after the first addressed mem_valid_i cycle.
  - Addressed means BASE_ADDR <= mem_addr_i < BASE_ADDR+20.
  - No re-acknowledge until mem_valid_i drops.
  - mem_rdata_o is 0 whenever mem_ready_o=0.
- Registers (offset: content):
  - 0x0 CTRL: write bit0=1 arms, write bit1=1 aborts; both self-clear and read 0.
  - 0x4 PULSE_WIDTH[15:0]: read/write.
  - 0x8 STATUS (read-only): [2:0] state code, [3] done, [4] timeout_err, [5] aborted.
  - 0xC VOUT_MIN[11:0]: read/write.
  - 0x10 FIRE_COUNT: see Optional Feature.
  - Unmapped offsets read 0.
- Sticky flags: done, timeout_err and aborted clear on the next accepted arm.
- State codes: IDLE=0, CHARGE=1, SETTLE=2, FIRE=3, COOLDOWN=4.
- IDLE:
  - Outputs: boost_enable_o=0, coil_gate_o=0.
  - Arm is accepted only if boost_init_finished_i=1 and PULSE_WIDTH!=0; otherwise it is ignored.
  - Accepted arm goes to CHARGE and clears the counter.
- CHARGE:
  - boost_enable_o=1; counter increments each cycle.
  - Go to SETTLE when counter>=ENABLE_LAG, boost_running_i=0 and vout_adc_i>=VOUT_MIN, all in the same cycle.
  - If counter reaches CHARGE_TIMEOUT first: timeout_err=1, irq_o pulse, go to IDLE.
- SETTLE: boost_enable_o=0; after exactly SETTLE_TIME cycles go to FIRE.
- FIRE:
  - coil_gate_o=1 for exactly PULSE_WIDTH cycles, then go to COOLDOWN.
  - PULSE_WIDTH is latched on entry to FIRE; writes during FIRE affect only the next shot.
- COOLDOWN:
  - coil_gate_o=0; after COOLDOWN_TIME cycles: done=1, irq_o pulse, go to IDLE.
- Arm while busy_o=1 is ignored.
- Abort, from any state:
  - Next cycle: state=IDLE, coil_gate_o=0, boost_enable_o=0, aborted=1, irq_o pulse.
  - Abort in IDLE sets only aborted (no irq_o pulse).
  - If arm and abort are written together, abort wins.
- Mutual exclusion invariant: coil_gate_o and boost_enable_o are never 1 in the same cycle.
- Outputs are registered; no combinational path from bus inputs to coil_gate_o.

Optional Feature:
- Macro FIRE_COUNT_EN.
- Defined: a 32-bit counter increments on each FIRE->COOLDOWN transition and wraps at 2^32-1 -> 0. It is readable at 0x10; any write to 0x10 clears it.
- Undefined: 0x10 reads 0, writes are ignored, and no counter is synthesized.

Test Plan:
- Setup: reset low 5 cycles, release. Write VOUT_MIN=0x800, PULSE_WIDTH=50, then arm.
  Model: boost_running_i=1 for 300 cycles then 0, vout_adc_i=0x820.
  Required: boost_enable_o high ~300 cycles; 200 cycles with both outputs low; coil_gate_o high exactly 50 cycles; done=1; one irq_o pulse.
- Arm with boost_init_finished_i=0 -> state stays IDLE, outputs 0. Arm with PULSE_WIDTH=0 -> ignored.
- CHARGE_TIMEOUT=1000, boost_running_i held 1 -> after 1000 cycles: timeout_err=1, irq_o pulse, boost_enable_o=0, coil_gate_o never asserted.
- Abort written on the 10th FIRE cycle (PULSE_WIDTH=50) -> coil_gate_o low the next cycle; aborted=1; STATUS reads state 0.
- Write PULSE_WIDTH=100 during FIRE of a 50-cycle shot -> that pulse is 50 cycles, the next shot is 100. Checker asserts coil_gate_o && boost_enable_o is never true.
- FIRE_COUNT_EN defined: 3 full shots -> 0x10 reads 3; a write to 0x10 clears it to 0. Undefined: 0x10 reads 0.

Source files
------------

// File: rtl/coil_fire_sequencer.sv
// coil_fire_sequencer: bus-mapped charge/settle/fire/cooldown shot sequencer.
// Define FIRE_COUNT_EN to add the shot counter at offset 0x10.
module coil_fire_sequencer #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0100,
  parameter logic [23:0] CHARGE_TIMEOUT = 24'd10000000,
  parameter logic [15:0] SETTLE_TIME    = 16'd200,
  parameter logic [23:0] COOLDOWN_TIME  = 24'd1000000,
  parameter logic [3:0]  ENABLE_LAG     = 4'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid_i,
  output logic        mem_ready_o,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  input  logic        boost_running_i,
  input  logic        boost_init_finished_i,
  input  logic [11:0] vout_adc_i,
  output logic        boost_enable_o,
  output logic        coil_gate_o,
  output logic        busy_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHARGE = 3'd1,
    S_SETTLE = 3'd2,
    S_FIRE   = 3'd3,
    S_COOL   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [15:0] pw_q, pw_d;
  logic [15:0] pwl_q, pwl_d;
  logic [11:0] vmin_q, vmin_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;
  logic        abt_q, abt_d;
  logic        acked_q, acked_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        boost_q, boost_d;
  logic        gate_q, gate_d;
  logic        busy_q, busy_d;
  logic        irq_q, irq_d;
`ifdef FIRE_COUNT_EN
  logic [31:0] fc_q, fc_d;
  logic        sel_fc;
`endif

  logic [31:0] off;
  logic        in_win, hit, wr, rd;
  logic        sel_ctrl, sel_pw, sel_stat, sel_vmin;
  logic        arm, abort;
  logic [23:0] cnt_inc;
  logic [31:0] rd_data;
  logic        unused;

  assign off      = mem_addr_i - BASE_ADDR;
  assign in_win   = (mem_addr_i >= BASE_ADDR) && (off < 32'd20);
  assign hit      = mem_valid_i && in_win && !acked_q;
  assign wr       = hit && (|mem_wstrb_i);
  assign rd       = hit && !(|mem_wstrb_i);
  assign sel_ctrl = (off[4:2] == 3'd0);
  assign sel_pw   = (off[4:2] == 3'd1);
  assign sel_stat = (off[4:2] == 3'd2);
  assign sel_vmin = (off[4:2] == 3'd3);
`ifdef FIRE_COUNT_EN
  assign sel_fc   = (off[4:2] == 3'd4);
`endif
  assign arm      = wr && sel_ctrl && mem_wdata_i[0];
  assign abort    = wr && sel_ctrl && mem_wdata_i[1];
  assign cnt_inc  = cnt_q + 24'd1;
  assign unused   = ^mem_wdata_i[31:16];

  always_comb begin
    rd_data = 32'd0;
    unique case (1'b1)
      sel_pw:   rd_data = {16'd0, pw_q};
      sel_stat: rd_data = {26'd0, abt_q, tmo_q, done_q, state_q};
      sel_vmin: rd_data = {20'd0, vmin_q};
`ifdef FIRE_COUNT_EN
      sel_fc:   rd_data = fc_q;
`endif
      default:  rd_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pw_d    = pw_q;
    pwl_d   = pwl_q;
    vmin_d  = vmin_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    abt_d   = abt_q;
    irq_d   = 1'b0;
    acked_d = mem_valid_i && (acked_q || hit);
    ready_d = hit;
    rdata_d = rd ? rd_data : 32'd0;
`ifdef FIRE_COUNT_EN
    fc_d    = fc_q;
`endif

    if (wr && sel_pw)   pw_d   = mem_wdata_i[15:0];
    if (wr && sel_vmin) vmin_d = mem_wdata_i[11:0];
`ifdef FIRE_COUNT_EN
    if (wr && sel_fc)   fc_d   = 32'd0;
`endif

    if (abort) begin
      abt_d   = 1'b1;
      irq_d   = (state_q != S_IDLE);
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm && boost_init_finished_i && pw_q != 16'd0) begin
            state_d = S_CHARGE;
            cnt_d   = 24'd0;
            done_d  = 1'b0;
            tmo_d   = 1'b0;
            abt_d   = 1'b0;
          end
        end
        S_CHARGE: begin
          if (cnt_q >= {20'd0, ENABLE_LAG} && !boost_running_i &&
              vout_adc_i >= vmin_q) begin
            state_d = S_SETTLE;
            cnt_d   = 24'd0;
          end else if (cnt_inc == CHARGE_TIMEOUT) begin
            tmo_d   = 1'b1;
            irq_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_SETTLE: begin
          if (cnt_inc == {8'd0, SETTLE_TIME}) begin
            cnt_d   = 24'd0;
            pwl_d   = pw_q;
            // a width cleared after arming yields no gate at all
            state_d = (pw_q == 16'd0) ? S_COOL : S_FIRE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_FIRE: begin
          if (cnt_inc == {8'd0, pwl_q}) begin
            cnt_d   = 24'd0;
            state_d = S_COOL;
`ifdef FIRE_COUNT_EN
            fc_d    = fc_q + 32'd1;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_COOL: begin
          if (cnt_inc == COOLDOWN_TIME) begin
            done_d  = 1'b1;
            irq_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    boost_d = (state_d == S_CHARGE);
    gate_d  = (state_d == S_FIRE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 24'd0;
      pw_q    <= 16'd0;
      pwl_q   <= 16'd0;
      vmin_q  <= 12'd0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      abt_q   <= 1'b0;
      acked_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      boost_q <= 1'b0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
`ifdef FIRE_COUNT_EN
      fc_q    <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      pwl_q   <= pwl_d;
      vmin_q  <= vmin_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      abt_q   <= abt_d;
      acked_q <= acked_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      boost_q <= boost_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
`ifdef FIRE_COUNT_EN
      fc_q    <= fc_d;
`endif
    end
  end

  assign mem_ready_o    = ready_q;
  assign mem_rdata_o    = rdata_q;
  assign boost_enable_o = boost_q;
  assign coil_gate_o    = gate_q;
  assign busy_o         = busy_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_coil_fire_sequencer.sv
// tb_coil_fire_sequencer: directed shots checked against a phase/countdown model.
// Build with FIRE_COUNT_EN defined to exercise the shot counter.
module tb_coil_fire_sequencer;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int CT  = 1000;
  localparam int ST  = 200;
  localparam int CD  = 300;
  localparam int LAG = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic [31:0] mem_rdata_o;
  logic        boost_running_i;
  logic        boost_init_finished_i;
  logic [11:0] vout_adc_i;
  logic        boost_enable_o;
  logic        coil_gate_o;
  logic        busy_o;
  logic        irq_o;

  coil_fire_sequencer #(
    .BASE_ADDR      (BASE),
    .CHARGE_TIMEOUT (24'd1000),
    .SETTLE_TIME    (16'd200),
    .COOLDOWN_TIME  (24'd300),
    .ENABLE_LAG     (4'd4)
  ) dut (
    .clk                   (clk),
    .reset                 (rst_n),
    .mem_valid_i           (mem_valid_i),
    .mem_ready_o           (mem_ready_o),
    .mem_addr_i            (mem_addr_i),
    .mem_wdata_i           (mem_wdata_i),
    .mem_wstrb_i           (mem_wstrb_i),
    .mem_rdata_o           (mem_rdata_o),
    .boost_running_i       (boost_running_i),
    .boost_init_finished_i (boost_init_finished_i),
    .vout_adc_i            (vout_adc_i),
    .boost_enable_o        (boost_enable_o),
    .coil_gate_o           (coil_gate_o),
    .busy_o                (busy_o),
    .irq_o                 (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: cycle budget expired (t=%0t)", nm, $time);
  endtask

  // model: phase = state code, m_left = cycles still to spend in phase
  logic [2:0]  m_ph;
  int          m_left, m_chg;
  logic [15:0] m_pw;
  logic [11:0] m_vmin;
  logic        m_done, m_tmo, m_abt, m_acked;
  logic [31:0] m_fc;
  logic        e_ready, e_irq;
  logic [31:0] e_rdata;

  function automatic logic [31:0] m_read(input logic [2:0] w);
    case (w)
      3'd1: return {16'd0, m_pw};
      3'd2: return {26'd0, m_abt, m_tmo, m_done, m_ph};
      3'd3: return {20'd0, m_vmin};
`ifdef FIRE_COUNT_EN
      3'd4: return m_fc;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_left = 0; m_chg = 0; m_pw = 0; m_vmin = 0;
    m_done = 0; m_tmo = 0; m_abt = 0; m_acked = 0; m_fc = 0;
    e_ready = 0; e_irq = 0; e_rdata = 0;
  endtask

  task automatic model_step();
    logic [31:0] o;
    logic [2:0]  w;
    logic        hit, wr, arm, abt;
    o   = mem_addr_i - BASE;
    w   = o[4:2];
    hit = mem_valid_i && (mem_addr_i >= BASE) && (o < 32'd20) && !m_acked;
    wr  = hit && (mem_wstrb_i != 4'd0);
    e_ready = hit;
    e_rdata = (hit && !wr) ? m_read(w) : 32'd0;
    m_acked = mem_valid_i && (m_acked || hit);
    arm = wr && (w == 3'd0) && mem_wdata_i[0];
    abt = wr && (w == 3'd0) && mem_wdata_i[1];
    e_irq = 0;
    if (abt) begin
      e_irq = (m_ph != 0);
      m_abt = 1;
      m_ph  = 0;
    end else begin
      case (m_ph)
        3'd0: if (arm && boost_init_finished_i && m_pw != 0) begin
          m_ph = 1; m_chg = 0; m_done = 0; m_tmo = 0; m_abt = 0;
        end
        3'd1: begin
          m_chg++;
          if (m_chg > LAG && !boost_running_i && vout_adc_i >= m_vmin) begin
            m_ph = 2; m_left = ST;
          end else if (m_chg == CT) begin
            m_tmo = 1; e_irq = 1; m_ph = 0;
          end
        end
        3'd2: begin
          m_left--;
          if (m_left == 0) begin
            if (m_pw == 0) begin m_ph = 4; m_left = CD; end
            else begin m_ph = 3; m_left = int'(m_pw); end
          end
        end
        3'd3: begin
          m_left--;
          if (m_left == 0) begin m_ph = 4; m_left = CD; m_fc++; end
        end
        3'd4: begin
          m_left--;
          if (m_left == 0) begin m_done = 1; e_irq = 1; m_ph = 0; end
        end
        default: m_ph = 0;
      endcase
    end
    if (wr && w == 3'd1) m_pw = mem_wdata_i[15:0];
    if (wr && w == 3'd3) m_vmin = mem_wdata_i[11:0];
`ifdef FIRE_COUNT_EN
    if (wr && w == 3'd4) m_fc = 0;
`endif
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    if (chk_en) begin
      chk("ready", mem_ready_o, e_ready);
      chk("rdata", mem_rdata_o, e_rdata);
      chk("boost", boost_enable_o, m_ph == 1);
      chk("gate", coil_gate_o, m_ph == 3);
      chk("busy", busy_o, m_ph != 0);
      chk("irq", irq_o, e_irq);
      chk("excl", coil_gate_o && boost_enable_o, 1'b0);
    end
  end

  int g_run = 0;
  int last_gate = 0;
  always @(negedge clk) begin
    if (coil_gate_o) g_run++;
    else if (g_run > 0) begin last_gate = g_run; g_run = 0; end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    @(negedge clk);
    mem_valid_i = 1; mem_addr_i = a; mem_wdata_i = d; mem_wstrb_i = 4'hf;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_ready_o) begin got = 1; break; end
    end
    mem_valid_i = 0; mem_wstrb_i = 0;
    if (!got) bound_fail("bus_write_ack");
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bit got = 0;
    d = 32'hdead_beef;
    @(negedge clk);
    mem_valid_i = 1; mem_addr_i = a; mem_wstrb_i = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_ready_o) begin got = 1; d = mem_rdata_o; break; end
    end
    repeat (2) @(negedge clk);
    mem_valid_i = 0;
    if (!got) bound_fail("bus_read_ack");
  endtask

  task automatic shot(input int drop_at, output int nb, output int ng,
                      output int nz, output int ni);
    bit fin = 0;
    nb = 0; ng = 0; nz = 0; ni = 0;
    for (int k = 0; k < 5000; k++) begin
      if (boost_enable_o) nb++;
      if (coil_gate_o) ng++;
      if (busy_o && !boost_enable_o && !coil_gate_o && nb > 0 && ng == 0) nz++;
      if (irq_o) ni++;
      if (k == drop_at) boost_running_i = 0;
      if (!busy_o) begin fin = 1; break; end
      @(negedge clk);
    end
    if (!fin) bound_fail("shot_end");
  endtask

  task automatic wait_idle();
    bit fin = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy_o) begin fin = 1; break; end
    end
    if (!fin) bound_fail("wait_idle");
  endtask

  task automatic wait_gate();
    bit fin = 0;
    for (int k = 0; k < 1000; k++) begin
      if (coil_gate_o) begin fin = 1; break; end
      @(negedge clk);
    end
    if (!fin) bound_fail("wait_gate");
  endtask

  logic [31:0] rv;
  int nb, ng, nz, ni;

  initial begin
    rst_n = 0;
    mem_valid_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_wstrb_i = 0;
    boost_running_i = 1; boost_init_finished_i = 1; vout_adc_i = 12'h820;
    repeat (5) @(negedge clk);
    chk("rst_boost", boost_enable_o, 0);
    chk("rst_gate", coil_gate_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_ready", mem_ready_o, 0);
    chk("rst_rdata", mem_rdata_o, 0);
    rst_n = 1;
    chk_en = 1;
    bus_read(BASE + 32'h8, rv);
    chk("rst_status", rv, 32'h0);

    // outside the window: never acknowledged
    @(negedge clk);
    mem_valid_i = 1; mem_addr_i = BASE + 32'h14; mem_wstrb_i = 0;
    repeat (3) @(negedge clk);
    mem_addr_i = BASE - 32'h4;
    repeat (3) @(negedge clk);
    chk("unmapped_noack", mem_ready_o, 0);
    mem_valid_i = 0;

    // nominal shot
    bus_write(BASE + 32'hC, 32'h800);
    bus_write(BASE + 32'h4, 32'd50);
    bus_read(BASE + 32'hC, rv);
    chk("vmin_rb", rv, 32'h800);
    bus_write(BASE + 32'h0, 32'h1);
    shot(299, nb, ng, nz, ni);
    chk("s1_boost_cycles", nb, 300);
    chk("s1_settle_cycles", nz, 200);
    chk("s1_gate_cycles", ng, 50);
    chk("s1_irq_pulses", ni, 1);
    bus_read(BASE + 32'h8, rv);
    chk("s1_status", rv, 32'h08);

    // arm ignored without calibration or with zero width
    boost_init_finished_i = 0;
    bus_write(BASE + 32'h0, 32'h1);
    repeat (3) @(negedge clk);
    chk("noinit_busy", busy_o, 0);
    boost_init_finished_i = 1;
    bus_write(BASE + 32'h4, 32'd0);
    bus_write(BASE + 32'h0, 32'h1);
    repeat (3) @(negedge clk);
    chk("pw0_busy", busy_o, 0);
    bus_read(BASE + 32'h8, rv);
    chk("ignored_status", rv, 32'h08);
    bus_write(BASE + 32'h4, 32'd50);

    // charge timeout
    boost_running_i = 1;
    bus_write(BASE + 32'h0, 32'h1);
    shot(-1, nb, ng, nz, ni);
    chk("to_boost_cycles", nb, CT);
    chk("to_gate_cycles", ng, 0);
    chk("to_irq_pulses", ni, 1);
    chk("to_boost_off", boost_enable_o, 0);
    bus_read(BASE + 32'h8, rv);
    chk("to_status", rv, 32'h10);

    // abort on the 10th fire cycle
    boost_running_i = 0;
    bus_write(BASE + 32'h0, 32'h1);
    wait_gate();
    repeat (8) @(negedge clk);
    bus_write(BASE + 32'h0, 32'h2);
    chk("ab_gate_low", coil_gate_o, 0);
    bus_read(BASE + 32'h8, rv);
    chk("ab_status", rv, 32'h20);
    chk("ab_gate_cycles", last_gate, 10);

    // width rewritten mid-pulse applies to the next shot only
    bus_write(BASE + 32'h0, 32'h1);
    wait_gate();
    bus_write(BASE + 32'h4, 32'd100);
    wait_idle();
    chk("pw_old_cycles", last_gate, 50);
    bus_write(BASE + 32'h0, 32'h1);
    wait_idle();
    chk("pw_new_cycles", last_gate, 100);

    // arm together with abort while idle: abort wins
    bus_write(BASE + 32'h0, 32'h3);
    repeat (2) @(negedge clk);
    chk("armabort_busy", busy_o, 0);
    bus_read(BASE + 32'h8, rv);
    chk("armabort_status", rv, 32'h28);

    bus_read(BASE + 32'h10, rv);
`ifdef FIRE_COUNT_EN
    chk("fire_count", rv, 32'd3);
`else
    chk("fire_count", rv, 32'd0);
`endif
    bus_write(BASE + 32'h10, 32'h0);
    bus_read(BASE + 32'h10, rv);
    chk("fire_count_clr", rv, 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
